cp0_except: RTL and testbench
=============================

// Module: cp0_except
// PURPOSE
//  M-stage exception source and CP0 register file. Collects per-instruction exception flags, pending
//  interrupts and ERET, prioritises them into ExceptSignal/ExceptType for the hazard unit, and supplies EPCM.
//  Holds Status, Cause, EPC, BadVAddr, Count and Compare. Services mtc0/mfc0 for the datapath.
// PARAMETERS
//  RESET_STATUS  32'h0040_0000  Status reset value (BEV=1, EXL=0, IE=0, IM=0)
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  rst              in   1   reset: synchronous, active-high
//  Cp0WriteM        in   1   mtc0 in M stage
//  Cp0WaddrM        in   5   mtc0 target register (rd)
//  Cp0WdataM        in   32  mtc0 data
//  Cp0RaddrE        in   5   mfc0 source register
//  Cp0RdataE        out  32  mfc0 data; combinational from current state
//  IntHw            in   6   hardware interrupt lines -> Cause.IP[7:2]
//  PCM              in   32  M-stage instruction PC
//  IsInDelaySlotM   in   1   M instruction is in a branch delay slot
//  AdelInstM/AdelDataM/AdesM  in  1 each  fetch/load misaligned, store misaligned
//  RiM/SyscallM/BreakM/OverflowM/EretM  in  1 each  decoded exception causes
//  BadAddrM         in   32  faulting data address (loads/stores)
//  ExceptSignal     out  1   an exception or ERET is taken this cycle
//  ExceptType       out  32  0x1 int, 0x4 AdEL, 0x5 AdES, 0x8 Sys, 0x9 Bp, 0xa RI, 0xc Ov, 0xe ERET, 0 none
//  EPCM             out  32  ERET return target
//  TimerInt         out  1   Cause.TI
// BEHAVIOUR
//  - Reset: Status=RESET_STATUS, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, TI=0, tick=0; outputs follow.
//  - Int pending = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
//  - ExceptType combinational, fixed priority: int > AdelInst > RI > Sys > Bp > Ov > AdelData > AdES > ERET.
//    ExceptSignal = (ExceptType != 0). Zero latency: same cycle as the M-stage flags.
//  - On clk with a non-ERET exception: EPC <= IsInDelaySlotM ? PCM-4 : PCM; Cause.BD <= IsInDelaySlotM;
//    Cause.ExcCode <= ExceptType[4:0]; Status.EXL <= 1. AdEL/AdES also load BadVAddr (PCM for AdelInst,
//    BadAddrM otherwise). Taking an exception with EXL already 1 still updates EPC/BD (no nesting protection).
//  - On clk with ERET: Status.EXL <= 0; no other register changes.
//  - EPCM = (Cp0WriteM & Cp0WaddrM==14) ? Cp0WdataM : EPC (mtc0 EPC immediately before/with ERET forwards).
//  - mtc0 writable fields: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; EPC, Count, Compare full 32 bits;
//    BadVAddr and Cause hardware fields read-only. Same-cycle exception wins over mtc0 for every field
//    the exception writes; a mtc0 in the excepting instruction itself is suppressed.
//  - Cause.IP[7:2] <= IntHw each cycle, with IP[7] |= TI.
//  - Count increments on every second clk (1-bit tick toggles each cycle); wraps 0xFFFF_FFFF -> 0.
//    mtc0 Count loads value and clears tick. Write to Compare clears TI.
//  - mfc0 reads: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC; all other indices read 0.
//  - rst during any activity returns to reset state on that edge; rst overrides exception and mtc0.
// CONFIGURATION
//  CP0_TIMER_INT_EN defined: Count==Compare on an increment edge sets TI (sticky until Compare write).
//  Not defined: Count/Compare still count and read/write normally; TI constant 0, IP[7] = IntHw[5] only.
// STRUCTURE
//  Package cp0_defs_pkg: CP0 register indices, ExcCode constants, ExceptType code constants, Status/Cause
//  bit positions. One sub-module cp0_timer: Count, tick, Compare, TI, load/clear controls.
// TESTING
//  1 Reset -> Status=0x0040_0000, Cause=0, ExceptSignal=0, Count=0; 10 idle cycles -> Count=5.
//  2 SyscallM=1, PCM=0xBFC0_0100, delay slot=1 -> ExceptType=0x8; next cycle EPC=0xBFC0_00FC, BD=1, EXL=1,
//    ExcCode=8.
//  3 OverflowM & AdesM same cycle, BadAddrM=0x1002 -> ExceptType=0xc; BadVAddr unchanged.
//  4 Status=0x0000_0401, IntHw[0]=1 -> ExceptType=0x1; with EXL=1 -> no exception.
//  5 mtc0 EPC=0x8000_0040 then EretM the same cycle -> EPCM=0x8000_0040, ExceptType=0xe; next EXL=0.
//  6 (CP0_TIMER_INT_EN) Compare=4, Count=0 -> TI=1 after 8 cycles; write Compare -> TI=0; undefined -> TI stays 0.

Source files
------------

// File: rtl/cp0_except_pkg.sv
// CP0 shared definitions: register indices, exception codes, ExceptType
// encodings and Status/Cause bit positions.
package cp0_defs_pkg;

  // mfc0/mtc0 register indices (rd field)
  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;

  // Exception code as written to Cause.ExcCode (ERET never reaches Cause)
  typedef enum logic [4:0] {
    EXC_NONE = 5'h00,
    EXC_INT  = 5'h01,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c,
    EXC_ERET = 5'h0e
  } exc_code_e;

  // ExceptType values seen by the hazard unit
  localparam logic [31:0] EXCEPT_TYPE_NONE = 32'h0000_0000;
  localparam logic [31:0] EXCEPT_TYPE_INT  = 32'h0000_0001;
  localparam logic [31:0] EXCEPT_TYPE_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXCEPT_TYPE_ADES = 32'h0000_0005;
  localparam logic [31:0] EXCEPT_TYPE_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXCEPT_TYPE_BP   = 32'h0000_0009;
  localparam logic [31:0] EXCEPT_TYPE_RI   = 32'h0000_000a;
  localparam logic [31:0] EXCEPT_TYPE_OV   = 32'h0000_000c;
  localparam logic [31:0] EXCEPT_TYPE_ERET = 32'h0000_000e;

  // Status / Cause field positions
  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IM_LO  = 8;
  localparam int CAUSE_EXC_LO  = 2;
  localparam int CAUSE_IP_LO   = 8;
  localparam int CAUSE_TI      = 30;
  localparam int CAUSE_BD      = 31;

  // ExceptType is the exception code zero-extended to 32 bits
  function automatic logic [31:0] to_except_type(exc_code_e code);
    return {27'b0, code};
  endfunction

endpackage

// File: rtl/cp0_except_if.sv
// M-stage datapath <-> CP0 bundle. master = datapath/hazard side, slave = CP0.
interface cp0_except_if;
  logic        Cp0WriteM;
  logic [4:0]  Cp0WaddrM;
  logic [31:0] Cp0WdataM;
  logic [4:0]  Cp0RaddrE;
  logic [31:0] Cp0RdataE;
  logic [5:0]  IntHw;
  logic [31:0] PCM;
  logic        IsInDelaySlotM;
  logic        AdelInstM;
  logic        AdelDataM;
  logic        AdesM;
  logic        RiM;
  logic        SyscallM;
  logic        BreakM;
  logic        OverflowM;
  logic        EretM;
  logic [31:0] BadAddrM;
  logic        ExceptSignal;
  logic [31:0] ExceptType;
  logic [31:0] EPCM;
  logic        TimerInt;

  modport master (
    output Cp0WriteM, Cp0WaddrM, Cp0WdataM, Cp0RaddrE, IntHw, PCM, IsInDelaySlotM,
           AdelInstM, AdelDataM, AdesM, RiM, SyscallM, BreakM, OverflowM, EretM, BadAddrM,
    input  Cp0RdataE, ExceptSignal, ExceptType, EPCM, TimerInt
  );

  modport slave (
    input  Cp0WriteM, Cp0WaddrM, Cp0WdataM, Cp0RaddrE, IntHw, PCM, IsInDelaySlotM,
           AdelInstM, AdelDataM, AdesM, RiM, SyscallM, BreakM, OverflowM, EretM, BadAddrM,
    output Cp0RdataE, ExceptSignal, ExceptType, EPCM, TimerInt
  );
endinterface

// File: rtl/cp0_except_timer.sv
// CP0 Count/Compare timer. Count advances every second clock via a 1-bit tick.
// With CP0_TIMER_INT_EN defined, Count reaching Compare on an increment edge
// raises a sticky TI that only a Compare write clears; otherwise TI stays 0.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;
  logic        ti_q, ti_d;
  logic [31:0] count_inc;

  // Next-state: tick/increment, then software loads override
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    count_inc = count_q + 32'd1;
    tick_d    = ~tick_q;
    count_d   = tick_q ? count_inc : count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
`ifdef CP0_TIMER_INT_EN
    if (tick_q && !count_we && (count_inc == compare_q)) ti_d = 1'b1;
`else
    ti_d      = 1'b0;
`endif
    if (count_we) begin
      count_d = wdata;
      tick_d  = 1'b0;
    end
    if (compare_we) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; all state here is plain flops,
    // each given an explicit reset value (there is no memory array to leave unreset).
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      tick_q    <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= tick_d;
      ti_q      <= ti_d;
    end
  end

  assign count     = count_q;
  assign compare   = compare_q;
  assign timer_int = ti_q;

endmodule

// File: rtl/cp0_except.sv
// M-stage exception prioritiser and CP0 register file (Status, Cause, EPC,
// BadVAddr, plus Count/Compare in cp0_timer). Optional timer interrupt is
// enabled by defining CP0_TIMER_INT_EN.
module cp0_except
  import cp0_defs_pkg::*;
#(
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input logic         clk,
  input logic         rst,
  cp0_except_if.slave bus
);

  logic [31:0] status_q, status_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  exc_code_e   exc_sel;
  logic        int_pending;
  logic        exc_take;
  logic        eret_take;
  logic        mtc0_en;
  logic [31:0] count, compare;
  logic        timer_int;
  logic [31:0] cp0_rdata;

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mtc0_en && (bus.Cp0WaddrM == CP0_REG_COUNT)),
    .compare_we (mtc0_en && (bus.Cp0WaddrM == CP0_REG_COMPARE)),
    .wdata      (bus.Cp0WdataM),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int)
  );

  // Fixed-priority exception select; a taken exception squashes its own mtc0
  always_comb begin
    int_pending = status_q[STATUS_IE] & ~status_q[STATUS_EXL] &
                  (|({ip_hw_q, ip_sw_q} & status_q[STATUS_IM_LO +: 8]));
    exc_sel = EXC_NONE;
    if (int_pending)         exc_sel = EXC_INT;
    else if (bus.AdelInstM)  exc_sel = EXC_ADEL;
    else if (bus.RiM)        exc_sel = EXC_RI;
    else if (bus.SyscallM)   exc_sel = EXC_SYS;
    else if (bus.BreakM)     exc_sel = EXC_BP;
    else if (bus.OverflowM)  exc_sel = EXC_OV;
    else if (bus.AdelDataM)  exc_sel = EXC_ADEL;
    else if (bus.AdesM)      exc_sel = EXC_ADES;
    else if (bus.EretM)      exc_sel = EXC_ERET;
    eret_take = (exc_sel == EXC_ERET);
    exc_take  = (exc_sel != EXC_NONE) && !eret_take;
    mtc0_en   = bus.Cp0WriteM && !exc_take;
  end

  // Register next-state: mtc0 first, then exception/ERET effects take precedence
  always_comb begin
    status_d   = status_q;
    bd_d       = bd_q;
    ip_hw_d    = bus.IntHw | {timer_int, 5'b0};
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (mtc0_en) begin
      case (bus.Cp0WaddrM)
        CP0_REG_STATUS: begin
          status_d[STATUS_IM_LO +: 8] = bus.Cp0WdataM[STATUS_IM_LO +: 8];
          status_d[STATUS_EXL]        = bus.Cp0WdataM[STATUS_EXL];
          status_d[STATUS_IE]         = bus.Cp0WdataM[STATUS_IE];
        end
        CP0_REG_CAUSE: ip_sw_d = bus.Cp0WdataM[CAUSE_IP_LO +: 2];
        CP0_REG_EPC:   epc_d   = bus.Cp0WdataM;
        default: ;
      endcase
    end
    if (exc_take) begin
      epc_d                = bus.IsInDelaySlotM ? (bus.PCM - 32'd4) : bus.PCM;
      bd_d                 = bus.IsInDelaySlotM;
      exc_code_d           = exc_sel;
      status_d[STATUS_EXL] = 1'b1;
      if (exc_sel == EXC_ADEL || exc_sel == EXC_ADES)
        badvaddr_d = bus.AdelInstM ? bus.PCM : bus.BadAddrM;
    end
    if (eret_take) status_d[STATUS_EXL] = 1'b0;
  end

  // CP0 state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= RESET_STATUS;
      bd_q       <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      status_q   <= status_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // mfc0 read mux over current state
  always_comb begin
    cp0_rdata = 32'd0;
    case (bus.Cp0RaddrE)
      CP0_REG_BADVADDR: cp0_rdata = badvaddr_q;
      CP0_REG_COUNT:    cp0_rdata = count;
      CP0_REG_COMPARE:  cp0_rdata = compare;
      CP0_REG_STATUS:   cp0_rdata = status_q;
      CP0_REG_CAUSE:    cp0_rdata = {bd_q, timer_int, 14'b0, ip_hw_q, ip_sw_q,
                                     1'b0, exc_code_q, 2'b00};
      CP0_REG_EPC:      cp0_rdata = epc_q;
      default:          cp0_rdata = 32'd0;
    endcase
  end

  assign bus.Cp0RdataE    = cp0_rdata;
  assign bus.ExceptType   = to_except_type(exc_sel);
  assign bus.ExceptSignal = (exc_sel != EXC_NONE);
  assign bus.EPCM         = (bus.Cp0WriteM && (bus.Cp0WaddrM == CP0_REG_EPC)) ? bus.Cp0WdataM : epc_q;
  assign bus.TimerInt     = timer_int;

endmodule

// File: tb/tb_cp0_except.sv
// Scoreboard bench for cp0_except: directed scenarios plus random stimulus,
// checked against a register-level reference model.
module tb_cp0_except;

`ifdef CP0_TIMER_INT_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cp0_except_if bus();

  cp0_except dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [5:0]  int_hw;
    logic [31:0] pc;
    logic        ds;
    logic        adel_i, adel_d, ades, ri, sys, brk, ov, eret;
    logic [31:0] bad;
  } stim_t;

  typedef struct packed {
    logic [31:0] status, epc, bad, count, cmp;
    logic        bd, ti, tick;
    logic [5:0]  iphw;
    logic [1:0]  ipsw;
    logic [4:0]  exc;
  } mstate_t;

  typedef struct packed {
    logic        sig;
    logic [31:0] etype;
    logic [31:0] epcm;
    logic [31:0] rdata;
    logic        ti;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t    exp_q[$];
  mstate_t m, pend;
  bit      m_ok = 0, pend_ok = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic mstate_t reset_m();
    mstate_t r = '0;
    r.status = 32'h0040_0000;
    return r;
  endfunction

  // Priority list, highest first: int, AdelInst, RI, Sys, Bp, Ov, AdelData, AdES, ERET
  function automatic logic [4:0] model_code(mstate_t ms, stim_t s);
    int  codes [9] = '{1, 4, 10, 8, 9, 12, 4, 5, 14};
    bit  flags [9];
    bit  int_pend;
    int_pend = ms.status[0] && !ms.status[1] && ((({ms.iphw, ms.ipsw}) & ms.status[15:8]) != 8'd0);
    flags = '{int_pend, s.adel_i, s.ri, s.sys, s.brk, s.ov, s.adel_d, s.ades, s.eret};
    for (int i = 0; i < 9; i++)
      if (flags[i]) return 5'(codes[i]);
    return 5'd0;
  endfunction

  function automatic exp_t model_out(mstate_t ms, stim_t s);
    exp_t e;
    logic [4:0] c = model_code(ms, s);
    e.etype = {27'd0, c};
    e.sig   = (c != 0);
    e.epcm  = (s.we && s.waddr == 5'd14) ? s.wdata : ms.epc;
    e.ti    = ms.ti;
    case (s.raddr)
      5'd8:    e.rdata = ms.bad;
      5'd9:    e.rdata = ms.count;
      5'd11:   e.rdata = ms.cmp;
      5'd12:   e.rdata = ms.status;
      5'd13:   e.rdata = (32'(ms.bd) << 31) | (32'(ms.ti) << 30) | (32'(ms.iphw) << 10) |
                         (32'(ms.ipsw) << 8) | (32'(ms.exc) << 2);
      5'd14:   e.rdata = ms.epc;
      default: e.rdata = 32'd0;
    endcase
    return e;
  endfunction

  function automatic mstate_t model_next(mstate_t ms, stim_t s);
    mstate_t n = ms;
    logic [4:0] c;
    bit exc, eret, wr;
    if (s.rst) return reset_m();
    c    = model_code(ms, s);
    exc  = (c != 0) && (c != 14);
    eret = (c == 14);
    wr   = s.we && !exc;
    // timer: advance on every second edge, loads win
    n.tick = !ms.tick;
    if (ms.tick) n.count = ms.count + 1;
    if (TIMER_EN && ms.tick && !(wr && s.waddr == 5'd9) && (ms.count + 1 == ms.cmp)) n.ti = 1'b1;
    if (wr && s.waddr == 5'd9)  begin n.count = s.wdata; n.tick = 1'b0; end
    if (wr && s.waddr == 5'd11) begin n.cmp = s.wdata; n.ti = 1'b0; end
    n.iphw = s.int_hw | (ms.ti ? 6'b100000 : 6'b0);
    if (wr && s.waddr == 5'd12)
      n.status = (ms.status & ~32'h0000_FF03) | (s.wdata & 32'h0000_FF03);
    if (wr && s.waddr == 5'd13) n.ipsw = s.wdata[9:8];
    if (wr && s.waddr == 5'd14) n.epc  = s.wdata;
    if (exc) begin
      n.epc       = s.ds ? s.pc - 4 : s.pc;
      n.bd        = s.ds;
      n.exc       = c;
      n.status[1] = 1'b1;
      if (c == 4 || c == 5) n.bad = s.adel_i ? s.pc : s.bad;
    end
    if (eret) n.status[1] = 1'b0;
    return n;
  endfunction

  // ---------------- stimulus ----------------
  function automatic stim_t idle();
    stim_t s = '0;
    return s;
  endfunction

  function automatic logic [4:0] pick_addr();
    case ($urandom_range(0, 6))
      0: return 5'd8;
      1: return 5'd9;
      2: return 5'd11;
      3: return 5'd12;
      4: return 5'd13;
      5: return 5'd14;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s = '0;
    s.rst    = ($urandom_range(0, 79) == 0);
    s.we     = ($urandom_range(0, 2) == 0);
    s.waddr  = pick_addr();
    s.wdata  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 15);
    s.raddr  = pick_addr();
    s.int_hw = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
    s.pc     = $urandom;
    s.ds     = 1'($urandom_range(0, 1));
    s.adel_i = ($urandom_range(0, 15) == 0);
    s.adel_d = ($urandom_range(0, 15) == 0);
    s.ades   = ($urandom_range(0, 15) == 0);
    s.ri     = ($urandom_range(0, 15) == 0);
    s.sys    = ($urandom_range(0, 15) == 0);
    s.brk    = ($urandom_range(0, 15) == 0);
    s.ov     = ($urandom_range(0, 15) == 0);
    s.eret   = ($urandom_range(0, 15) == 0);
    s.bad    = $urandom;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst                = s.rst;
    bus.Cp0WriteM      = s.we;
    bus.Cp0WaddrM      = s.waddr;
    bus.Cp0WdataM      = s.wdata;
    bus.Cp0RaddrE      = s.raddr;
    bus.IntHw          = s.int_hw;
    bus.PCM            = s.pc;
    bus.IsInDelaySlotM = s.ds;
    bus.AdelInstM      = s.adel_i;
    bus.AdelDataM      = s.adel_d;
    bus.AdesM          = s.ades;
    bus.RiM            = s.ri;
    bus.SyscallM       = s.sys;
    bus.BreakM         = s.brk;
    bus.OverflowM      = s.ov;
    bus.EretM          = s.eret;
    bus.BadAddrM       = s.bad;
  endtask

  // One clock cycle: commit the model's pending edge, drive, predict, queue the expectation
  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    if (pend_ok) begin
      m    = pend;
      m_ok = 1;
    end
    apply(s);
    if (m_ok) exp_q.push_back(model_out(m, s));
    pend    = model_next(m, s);
    pend_ok = m_ok || s.rst;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("except_signal", {31'd0, bus.ExceptSignal}, {31'd0, e.sig});
        check("except_type",   bus.ExceptType, e.etype);
        check("epcm",          bus.EPCM,       e.epcm);
        check("cp0_rdata",     bus.Cp0RdataE,  e.rdata);
        check("timer_int",     {31'd0, bus.TimerInt}, {31'd0, e.ti});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required completion", $time);
    $fatal(1, "time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    stim_t s;
    apply(idle());
    rst = 1'b1;

    // 1: reset state and Count rate
    s = idle(); s.rst = 1'b1; step(s);
    s = idle(); s.raddr = 5'd12; step(s); #1;
    check("t1_status_reset", bus.Cp0RdataE, 32'h0040_0000);
    check("t1_no_except", {31'd0, bus.ExceptSignal}, 32'd0);
    s = idle(); s.raddr = 5'd13; step(s); #1;
    check("t1_cause_reset", bus.Cp0RdataE, 32'd0);
    repeat (8) step(idle());
    s = idle(); s.raddr = 5'd9; step(s); #1;
    check("t1_count_after_10", bus.Cp0RdataE, 32'd5);

    // 2: syscall in a delay slot
    s = idle(); s.sys = 1'b1; s.pc = 32'hBFC0_0100; s.ds = 1'b1; step(s); #1;
    check("t2_type_sys", bus.ExceptType, 32'h8);
    s = idle(); s.raddr = 5'd14; step(s); #1;
    check("t2_epc", bus.Cp0RdataE, 32'hBFC0_00FC);
    s = idle(); s.raddr = 5'd13; step(s); #1;
    check("t2_cause_bd_exc", bus.Cp0RdataE & 32'h8000_007C, 32'h8000_0020);
    s = idle(); s.raddr = 5'd12; step(s); #1;
    check("t2_exl", bus.Cp0RdataE & 32'h2, 32'h2);

    // 3: overflow outranks AdES; BadVAddr untouched
    s = idle(); s.ov = 1'b1; s.ades = 1'b1; s.bad = 32'h1002; step(s); #1;
    check("t3_type_ov", bus.ExceptType, 32'hc);
    s = idle(); s.raddr = 5'd8; step(s); #1;
    check("t3_badvaddr", bus.Cp0RdataE, 32'd0);

    // 4: hardware interrupt, then masked by EXL
    s = idle(); s.we = 1'b1; s.waddr = 5'd12; s.wdata = 32'h0000_0401; s.int_hw = 6'd1; step(s);
    s = idle(); s.int_hw = 6'd1; step(s); #1;
    check("t4_type_int", bus.ExceptType, 32'h1);
    s = idle(); s.int_hw = 6'd1; step(s); #1;
    check("t4_exl_masks", {31'd0, bus.ExceptSignal}, 32'd0);

    // 5: mtc0 EPC forwarded to a same-cycle ERET
    s = idle(); s.we = 1'b1; s.waddr = 5'd12; s.wdata = 32'h0000_0002; step(s);
    s = idle(); s.we = 1'b1; s.waddr = 5'd14; s.wdata = 32'h8000_0040; s.eret = 1'b1; step(s); #1;
    check("t5_epcm_fwd", bus.EPCM, 32'h8000_0040);
    check("t5_type_eret", bus.ExceptType, 32'he);
    s = idle(); s.raddr = 5'd12; step(s); #1;
    check("t5_status_exl_clr", bus.Cp0RdataE, 32'h0040_0000);

    // 6: timer compare
    s = idle(); s.we = 1'b1; s.waddr = 5'd11; s.wdata = 32'd4; step(s);
    s = idle(); s.we = 1'b1; s.waddr = 5'd9;  s.wdata = 32'd0; step(s);
    repeat (7) step(idle());
    s = idle(); step(s); #1;
    check("t6_ti_before", {31'd0, bus.TimerInt}, 32'd0);
    s = idle(); s.raddr = 5'd9; step(s); #1;
    check("t6_ti_set", {31'd0, bus.TimerInt}, {31'd0, TIMER_EN});
    s = idle(); s.we = 1'b1; s.waddr = 5'd11; s.wdata = 32'd100; step(s);
    s = idle(); step(s); #1;
    check("t6_ti_cleared", {31'd0, bus.TimerInt}, 32'd0);

    // random phase
    for (int i = 0; i < 400; i++) step(rand_stim());

    @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
